// File: rtl/mux2x1_rr_arbiter.sv
// Round-robin arbiter sharing a 2:1 muxed valid/ready output channel between
// two requesters, with bounded bursts and bubble-free handover.
module mux2x1_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAXBURST = 4
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic             y_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic             s,
    output logic             gnt0,
    output logic             gnt1,
    output logic             ack0,
    output logic             ack1
);

    localparam int CW = (MAXBURST < 1) ? 1 : $clog2(MAXBURST + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          last;
    logic          xfer;
    logic          burst_done;
    logic          rel0;
    logic          rel1;

    always_comb begin
        y          = s ? a1 : a0;
        y_valid    = (gnt0 & req0) | (gnt1 & req1);
        ack0       = gnt0 & req0 & y_ready;
        ack1       = gnt1 & req1 & y_ready;
        xfer       = y_valid & y_ready;
        cnt_inc    = cnt + CW'(1);
        burst_done = xfer & (cnt_inc == CW'(MAXBURST));
        rel0       = ~req0 | burst_done;
        rel1       = ~req1 | burst_done;
    end

    // last records the requester whose grant was most recently released,
    // so an IDLE tie goes to the other one.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            s     <= 1'b0;
            cnt   <= '0;
            last  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req0 && (!req1 || last)) begin
                        state <= G0;
                        gnt0  <= 1'b1;
                        gnt1  <= 1'b0;
                        s     <= 1'b0;
                    end else if (req1) begin
                        state <= G1;
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b1;
                        s     <= 1'b1;
                    end
                end
                G0: begin
                    if (rel0) begin
                        cnt  <= '0;
                        last <= 1'b0;
                        if (req1) begin
                            state <= G1;
                            gnt0  <= 1'b0;
                            gnt1  <= 1'b1;
                            s     <= 1'b1;
                        end else if (!req0) begin
                            state <= IDLE;
                            gnt0  <= 1'b0;
                        end
                    end else if (xfer) begin
                        cnt <= cnt_inc;
                    end
                end
                G1: begin
                    if (rel1) begin
                        cnt  <= '0;
                        last <= 1'b1;
                        if (req0) begin
                            state <= G0;
                            gnt0  <= 1'b1;
                            gnt1  <= 1'b0;
                            s     <= 1'b0;
                        end else if (!req1) begin
                            state <= IDLE;
                            gnt1  <= 1'b0;
                        end
                    end else if (xfer) begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux2x1_rr_arbiter.sv
// Directed self-checking bench for mux2x1_rr_arbiter (WIDTH=8, MAXBURST=4).
module tb_mux2x1_rr_arbiter;

    logic       clk = 1'b0;
    logic       clrn;
    logic       req0, req1;
    logic [7:0] a0, a1;
    logic       y_ready;
    logic [7:0] y;
    logic       y_valid, s, gnt0, gnt1, ack0, ack1;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    mux2x1_rr_arbiter #(.WIDTH(8), .MAXBURST(4)) dut (
        .clk     (clk),
        .clrn    (clrn),
        .req0    (req0),
        .req1    (req1),
        .a0      (a0),
        .a1      (a1),
        .y_ready (y_ready),
        .y       (y),
        .y_valid (y_valid),
        .s       (s),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .ack0    (ack0),
        .ack1    (ack1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance from one falling edge to the next (one rising edge in between).
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_outs(input string tag, input logic g0, input logic g1, input logic sel,
                            input logic vld, input logic k0, input logic k1);
        check({tag, ".gnt0"},    32'(gnt0),    32'(g0));
        check({tag, ".gnt1"},    32'(gnt1),    32'(g1));
        check({tag, ".s"},       32'(s),       32'(sel));
        check({tag, ".y_valid"}, 32'(y_valid), 32'(vld));
        check({tag, ".ack0"},    32'(ack0),    32'(k0));
        check({tag, ".ack1"},    32'(ack1),    32'(k1));
    endtask

    // Pulse reset for one cycle and release on a falling edge with both requesting.
    task automatic restart();
        clrn    = 1'b0;
        req0    = 1'b1;
        req1    = 1'b1;
        y_ready = 1'b1;
        tick();
        clrn = 1'b1;
    endtask

    initial begin
        a0      = 8'hA5;
        a1      = 8'h3C;
        req0    = 1'b1;
        req1    = 1'b1;
        y_ready = 1'b1;
        clrn    = 1'b0;
        @(negedge clk);
        tick();
        tick();

        // Reset held with both requesting
        #1 chk_outs("reset", 0, 0, 0, 0, 0, 0);
        clrn = 1'b1;
        tick();
        #1 chk_outs("first_grant", 1, 0, 0, 1, 1, 0);
        check("first_grant.y", 32'(y), 32'h A5);

        // Contention: 4 beats each, alternating, no bubbles
        for (int i = 1; i < 17; i++) begin
            logic es;
            tick();
            es = ((i / 4) % 2) == 1;
            #1 chk_outs($sformatf("contend%0d", i), !es, es, es, 1, !es, es);
            check($sformatf("contend%0d.y", i), 32'(y), es ? 32'h3C : 32'hA5);
        end

        // Single requester: continuous re-grant, gnt1 never rises
        restart();
        req1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            #1 chk_outs($sformatf("single%0d", i), 1, 0, 0, 1, 1, 0);
            check($sformatf("single%0d.y", i), 32'(y), 32'h A5);
        end

        // Backpressure in G1 after two beats
        restart();
        for (int i = 0; i < 4; i++) tick();
        tick();
        #1 chk_outs("bp_g1_b1", 0, 1, 1, 1, 0, 1);
        tick();
        #1 chk_outs("bp_g1_b2", 0, 1, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            y_ready = 1'b0;
            #1 chk_outs($sformatf("bp_stall%0d", i), 0, 1, 1, 1, 0, 0);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            y_ready = 1'b1;
            #1 chk_outs($sformatf("bp_resume%0d", i), 0, 1, 1, 1, 0, 1);
        end
        tick();
        #1 chk_outs("bp_handover", 1, 0, 0, 1, 1, 0);

        // Early drop in G1 with req0 waiting
        restart();
        for (int i = 0; i < 5; i++) tick();
        #1 chk_outs("drop_g1_b1", 0, 1, 1, 1, 0, 1);
        tick();
        req1 = 1'b0;
        #1 chk_outs("drop_novalid", 0, 1, 1, 0, 0, 0);
        tick();
        #1 chk_outs("drop_to_g0", 1, 0, 0, 1, 1, 0);

        // Early drop in G1 with nobody waiting
        restart();
        for (int i = 0; i < 5; i++) tick();
        tick();
        req0 = 1'b0;
        req1 = 1'b0;
        #1 chk_outs("drop2_novalid", 0, 1, 1, 0, 0, 0);
        tick();
        #1 chk_outs("drop2_idle", 0, 0, 1, 0, 0, 0);
        check("drop2_idle.y", 32'(y), 32'h3C);

        // Asynchronous reset at beat 3 of G0
        restart();
        for (int i = 0; i < 3; i++) tick();
        #1 chk_outs("ar_beat3", 1, 0, 0, 1, 1, 0);
        #2 clrn = 1'b0;
        #1 chk_outs("ar_abort", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        clrn = 1'b1;
        tick();
        #1 chk_outs("ar_regrant", 1, 0, 0, 1, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux2x1_rr_arbiter.md
# mux2x1_rr_arbiter

Round-robin arbiter that shares one 2-to-1 multiplexed output channel between two requesters. It sequences the mux select, grants the channel to one requester at a time for a bounded burst, and hands over between requesters with no idle bubble. It sits in front of a downstream consumer that uses a valid/ready handshake.

## Interface
Parameters:
- WIDTH, 8, data width of each requester and of the output.
- MAXBURST, 4, maximum beats per grant before re-arbitration (≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clrn  in  1  reset, asynchronous, active-low.
- req0  in  1  requester 0 has a beat on a0.
- req1  in  1  requester 1 has a beat on a1.
- a0  in  WIDTH  requester 0 data.
- a1  in  WIDTH  requester 1 data.
- y_ready  in  1  downstream accepts a beat this cycle.
- y  out  WIDTH  output data, combinational `s ? a1 : a0`.
- y_valid  out  1  combinational `(gnt0 & req0) | (gnt1 & req1)`.
- s  out  1  registered mux select.
- gnt0, gnt1  out  1  registered grants, one-hot or both 0.
- ack0, ack1  out  1  combinational `gntN & reqN & y_ready`; beat N consumed.

## Operation
- State: IDLE, G0, G1 (gnt0 = G0, gnt1 = G1). Also `last` (last granted requester, 1 bit) and beat counter `cnt` (0..MAXBURST).
- Transfer occurs in a cycle when y_valid & y_ready. cnt increments on each transfer; it is cleared on every grant or re-grant.
- IDLE: both req → grant the requester ≠ last. One req → grant it. None → stay. s holds its previous value in IDLE.
- G0 (G1 symmetric), evaluated at each edge:
  - Release condition: req0 low, or a transfer that makes cnt reach MAXBURST.
  - If released and req1 high → G1, cnt=0, last=0.
  - If released, req1 low, req0 high (burst expiry) → stay G0, cnt=0.
  - If released, neither req → IDLE.
  - Otherwise stay, cnt updated.
- s = 0 in G0, 1 in G1; s updates on the same edge as the grant.
- Requesters hold reqN and aN stable until ackN. A req dropped without ack transfers nothing: y_valid goes low in that cycle and the grant releases at the next edge.
- y_ready low freezes cnt and the grant. This is not a release condition.

## Timing
- Reset (clrn=0, asynchronous): state IDLE; gnt0=gnt1=0; s=0; cnt=0; last=1, so requester 0 wins the first tie. y_valid=0 and ack0=ack1=0 follow combinationally. Reset mid-burst aborts immediately with no further acks.
- Grant latency: a req sampled high at edge k in IDLE gives gnt asserted after edge k. The first y_valid and ack occur in cycle k+1.
- Handover G0↔G1 happens on one edge: the last beat of one requester and the first beat of the other are in consecutive cycles.
- Steady contention with y_ready=1: exactly MAXBURST beats per grant, alternating requesters.
- Throughput: 1 beat/cycle while granted and ready.

## Test plan
- Reset: hold clrn=0 with req0=req1=1 → gnt0=gnt1=0, s=0, y_valid=0, ack0=ack1=0. Release clrn → gnt0=1 after the first edge.
- Single requester: req0=1, a0=8'hA5, y_ready=1 for 10 cycles → gnt0 from cycle 1, y=8'hA5, ack0 every cycle. Re-grant after 4 beats with no gap. gnt1 never asserts.
- Contention: req0=req1=1, a1=8'h3C, y_ready=1 → 4 beats with s=0, then 4 beats with s=1 (y=8'h3C), alternating. No cycle with y_valid=0 after the first grant.
- Backpressure: during a G1 burst after beat 2, y_ready=0 for 3 cycles → gnt1 held, ack1=0, cnt stays 2. After y_ready=1, exactly 2 more beats before handover.
- Early drop: in G1, req1 falls after 1 beat with req0=1 → G0 at the next edge (s=0). Repeat with req0=0 → IDLE, s stays 1, y_valid=0.
- Async reset mid-burst: assert clrn=0 between edges at beat 3 of G0 → gnt0 and y_valid drop immediately, s=0. After release with both requesting, requester 0 is granted first.
